swipt_frame_rx: RTL

Bit-serial frame receiver for the SWIPT downlink: the far-end decoder for the 36-bit frames the base-station data controller shifts out on its `dout` line. It synchronises the incoming line, times bits from the leading edge, validates preamble, trailer and parity, and presents the decoded mode, type and 16-bit payload with a one-cycle valid strobe. It sits on the receiving (drone-side) board between the demodulated line input and the command/telemetry logic.

---
 rtl/swipt_frame_pkg.sv | 24 ++
 rtl/swipt_bit_sampler.sv | 62 ++++++
 rtl/swipt_frame_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/swipt_frame_pkg.sv
// swipt_frame_pkg: shared constants and state type for the SWIPT downlink
// frame receiver.
// Frame layout, MSB (bit 35) first on the line:
//   [35:30] preamble  [29:28] mode  [27:26] type  [25:10] data
//   [9]     parity    [8:4]   reserved (ignored)  [3:0]   trailer
package swipt_frame_pkg;

  localparam int unsigned FRAME_BITS = 36;

  localparam logic [5:0] PREAMBLE = 6'b101010;
  localparam logic [3:0] TRAILER  = 4'b0101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_PREAMBLE = 2'b01;
  localparam logic [1:0] ERR_PARITY   = 2'b10;
  localparam logic [1:0] ERR_TRAILER  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } rx_state_t;

endpackage

// File: rtl/swipt_bit_sampler.sv
// swipt_bit_sampler: per-bit period counter and sample strobe generation.
// Counter phase 0 is the edge-detect cycle, so the mid-bit sample lands
// BIT_PERIOD/2 cycles after each bit's leading edge.
// SWIPT_FRAME_RX_MAJORITY_EN: sample at 1/4, 1/2 and 3/4 of the bit and
// deliver a 2-of-3 vote at the 3/4 point; otherwise one sample at 1/2.
module swipt_bit_sampler #(
  parameter int unsigned BIT_PERIOD = 200000
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  input  logic run,
  input  logic din,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int unsigned CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_PERIOD / 2);

  logic [CW-1:0] cnt;

  // Period counter; loading 1 on start makes the edge cycle count as phase 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

`ifdef SWIPT_FRAME_RX_MAJORITY_EN
  localparam logic [CW-1:0] QUART  = CW'(BIT_PERIOD / 4);
  localparam logic [CW-1:0] TQUART = CW'((3 * BIT_PERIOD) / 4);

  logic s_quart;
  logic s_half;

  // Capture the first two votes; the third is taken live at the 3/4 point.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_quart <= 1'b0;
      s_half  <= 1'b0;
    end else if (run) begin
      if (cnt == QUART) s_quart <= din;
      if (cnt == HALF)  s_half  <= din;
    end
  end

  assign bit_strobe = run && (cnt == TQUART);
  assign bit_val    = (s_quart & s_half) | (s_quart & din) | (s_half & din);
`else
  assign bit_strobe = run && (cnt == HALF);
  assign bit_val    = din;
`endif

endmodule

// File: rtl/swipt_frame_rx.sv
// swipt_frame_rx: bit-serial 36-bit SWIPT downlink frame receiver.
// Synchronises rx_in, starts on a rising edge, checks preamble early and
// trailer/parity at the end, and pulses rx_valid or rx_err for one cycle.
// Optional build macro: SWIPT_FRAME_RX_MAJORITY_EN (3-point majority sampling).
module swipt_frame_rx
  import swipt_frame_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 200000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        rx_in,
  output logic [1:0]  rx_mode,
  output logic [1:0]  rx_type,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  rx_state_t   state;
  logic        sync1;
  logic        sync2;
  logic        sync_prev;
  logic        rise;
  logic        start;
  logic        run;
  logic        bit_strobe;
  logic        bit_val;
  logic [5:0]  bit_cnt;
  // Only frame bits [29:1] need retaining: the preamble is checked on the
  // fly at bit 30 and bit 0 arrives live as bit_val when the frame closes.
  logic [28:0] sr;
  logic [15:0] frm_data;
  logic [1:0]  done_code;

  // Two-flop synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise  = sync2 & ~sync_prev;
  assign start = (state == ST_IDLE) && enable && rise;
  assign run   = (state == ST_SHIFT);
  assign busy  = (state != ST_IDLE);

  swipt_bit_sampler #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_sampler (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .run        (run),
    .din        (sync2),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  assign frm_data = sr[24:9];

  // End-of-frame verdict, evaluated while bit 0 is being sampled.
  always_comb begin
    done_code = ERR_NONE;
    if ({sr[2:0], bit_val} != TRAILER) begin
      done_code = ERR_TRAILER;
    end else if (sr[8] != ^frm_data) begin
      done_code = ERR_PARITY;
    end
  end

  // Receive FSM with shift register and registered result outputs.
  // Verdicts are registered on the bit-0 strobe so the pulse coincides with
  // the single DONE cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      rx_mode  <= '0;
      rx_type  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state   <= ST_SHIFT;
              bit_cnt <= 6'd35;
            end
          end
          ST_SHIFT: begin
            if (bit_strobe) begin
              sr <= {sr[27:0], bit_val};
              if ((bit_cnt == 6'd30) && ({sr[4:0], bit_val} != PREAMBLE)) begin
                rx_err   <= 1'b1;
                err_code <= ERR_PREAMBLE;
                state    <= ST_IDLE;
              end else if (bit_cnt == 6'd0) begin
                state <= ST_DONE;
                if (done_code == ERR_NONE) begin
                  rx_valid <= 1'b1;
                  rx_mode  <= sr[28:27];
                  rx_type  <= sr[26:25];
                  rx_data  <= frm_data;
                end else begin
                  rx_err   <= 1'b1;
                  err_code <= done_code;
                end
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
